// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - phase-sequenced program counter with optional return stack
//
// Optional feature macro: CALL_STACK_EN (compiles in a STACK_DEPTH-entry LIFO return stack)
//
// Parameters:
//   PC_W        program counter width
//   NPHASE      phases per instruction (2..8)
//   UPD_PHASE   phase in which pc is updated (0..NPHASE-1)
//   STACK_DEPTH return-stack entries (1..16), only meaningful with CALL_STACK_EN
// Ports:
//   clk      clock, all state changes on rising edge
//   rst      synchronous active-high reset
//   run      start request, sampled in IDLE
//   halt     stop request (level), acted on in the last phase
//   jflag    jump at the update phase
//   jdest    jump/call target
//   call     subroutine call at the update phase
//   ret      subroutine return at the update phase
//   phase    current phase index
//   pc       registered program counter
//   pc_we    high during the update cycle
//   running  high in RUN
//   stk_err  sticky stack overflow/underflow flag

module pc_sequencer #(
  parameter int PC_W        = 12,
  parameter int NPHASE      = 5,
  parameter int UPD_PHASE   = 2,
  parameter int STACK_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic            halt,
  input  logic            jflag,
  input  logic [PC_W-1:0] jdest,
  input  logic            call,
  input  logic            ret,
  output logic [2:0]      phase,
  output logic [PC_W-1:0] pc,
  output logic            pc_we,
  output logic            running,
  output logic            stk_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [2:0] LAST_PH = 3'(NPHASE - 1);
  localparam logic [2:0] UPD_PH  = 3'(UPD_PHASE);

  state_t          state;
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] pc_next;

  // Natural overflow of the adder gives the required all-ones -> 0 wrap.
  assign pc_inc = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign pc_we  = (state == S_RUN) && (phase == UPD_PH);

`ifdef CALL_STACK_EN
  localparam int SP_W  = $clog2(STACK_DEPTH + 1);
  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [PC_W-1:0] stack_mem [STACK_DEPTH];
  logic [SP_W-1:0] sp;
  logic            stk_full;
  logic            stk_empty;
  logic            do_push;
  logic            do_pop;
  logic            err_set;

  assign stk_full  = (sp == SP_W'(STACK_DEPTH));
  assign stk_empty = (sp == '0);

  // Priority ret > call > jflag > increment. A ret on an empty stack
  // degrades to an increment; a call on a full stack still jumps.
  always_comb begin
    pc_next = pc_inc;
    do_push = 1'b0;
    do_pop  = 1'b0;
    err_set = 1'b0;
    if (ret) begin
      if (stk_empty) begin
        err_set = 1'b1;
      end else begin
        pc_next = stack_mem[IDX_W'(sp - 1'b1)];
        do_pop  = 1'b1;
      end
    end else if (call) begin
      pc_next = jdest;
      if (stk_full) begin
        err_set = 1'b1;
      end else begin
        do_push = 1'b1;
      end
    end else if (jflag) begin
      pc_next = jdest;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sp      <= '0;
      stk_err <= 1'b0;
    end else if (pc_we) begin
      if (do_push) begin
        stack_mem[IDX_W'(sp)] <= pc_inc;
        sp                    <= sp + 1'b1;
      end else if (do_pop) begin
        sp <= sp - 1'b1;
      end
      if (err_set) begin
        stk_err <= 1'b1;
      end
    end
  end
`else
  logic unused_stack;

  // Without a stack, call is just another jump and ret has no meaning.
  assign pc_next      = (call || jflag) ? jdest : pc_inc;
  assign stk_err      = 1'b0;
  assign unused_stack = ret | (STACK_DEPTH == 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      phase   <= 3'd0;
      pc      <= '0;
      running <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          phase <= 3'd0;
          if (run) begin
            state   <= S_RUN;
            running <= 1'b1;
          end
        end
        S_RUN: begin
          if (pc_we) begin
            pc <= pc_next;
          end
          // halt is only honoured once the current instruction is finished.
          if (phase == LAST_PH) begin
            phase <= 3'd0;
            if (halt) begin
              state   <= S_HALT;
              running <= 1'b0;
            end
          end else begin
            phase <= phase + 3'd1;
          end
        end
        S_HALT: begin
          phase   <= 3'd0;
          running <= 1'b0;
        end
        default: begin
          state   <= S_IDLE;
          phase   <= 3'd0;
          running <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - randomized self-checking bench for pc_sequencer

module tb_pc_sequencer;

  localparam int PC_W        = 12;
  localparam int NPHASE      = 5;
  localparam int UPD_PHASE   = 2;
  localparam int STACK_DEPTH = 4;
  localparam int PC_MOD      = 1 << PC_W;

  logic            clk;
  logic            rst;
  logic            run;
  logic            halt;
  logic            jflag;
  logic [PC_W-1:0] jdest;
  logic            call;
  logic            ret;
  logic [2:0]      phase;
  logic [PC_W-1:0] pc;
  logic            pc_we;
  logic            running;
  logic            stk_err;

  int checks   = 0;
  int failures = 0;

  // Reference model: mode 0 = idle, 1 = running, 2 = halted.
  int          m_mode;
  int          m_ph;
  int unsigned m_pc;
  bit          m_err;
  int unsigned m_stk[$];

  pc_sequencer #(
    .PC_W       (PC_W),
    .NPHASE     (NPHASE),
    .UPD_PHASE  (UPD_PHASE),
    .STACK_DEPTH(STACK_DEPTH)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .run    (run),
    .halt   (halt),
    .jflag  (jflag),
    .jdest  (jdest),
    .call   (call),
    .ret    (ret),
    .phase  (phase),
    .pc     (pc),
    .pc_we  (pc_we),
    .running(running),
    .stk_err(stk_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic model_step();
    int unsigned nxt;
    if (rst) begin
      m_mode = 0;
      m_ph   = 0;
      m_pc   = 0;
      m_err  = 0;
      m_stk.delete();
    end else if (m_mode == 0) begin
      if (run) begin
        m_mode = 1;
        m_ph   = 0;
      end
    end else if (m_mode == 1) begin
      if (m_ph == UPD_PHASE) begin
        nxt = (m_pc + 1) % PC_MOD;
`ifdef CALL_STACK_EN
        if (ret) begin
          if (m_stk.size() > 0) nxt = m_stk.pop_back();
          else m_err = 1;
        end else if (call) begin
          if (m_stk.size() < STACK_DEPTH) m_stk.push_back((m_pc + 1) % PC_MOD);
          else m_err = 1;
          nxt = jdest;
        end else if (jflag) begin
          nxt = jdest;
        end
`else
        if (call || jflag) nxt = jdest;
`endif
        m_pc = nxt;
      end
      if (m_ph == NPHASE - 1) begin
        m_ph = 0;
        if (halt) m_mode = 2;
      end else begin
        m_ph++;
      end
    end
  endtask

  task automatic check_all();
    check("phase", phase, m_ph);
    check("pc", pc, m_pc);
    check("running", running, (m_mode == 1) ? 1 : 0);
    check("pc_we", pc_we, (m_mode == 1 && m_ph == UPD_PHASE) ? 1 : 0);
    check("stk_err", stk_err, m_err);
  endtask

  task automatic cycle(input logic r, input logic rn, input logic h, input logic j,
                       input logic [PC_W-1:0] jd, input logic c, input logic rt);
    rst   = r;
    run   = rn;
    halt  = h;
    jflag = j;
    jdest = jd;
    call  = c;
    ret   = rt;
    model_step();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic idle_cycle();
    cycle(1'b0, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic run_to_phase(input int p);
    int n = 0;
    while (m_ph != p && n < 20) begin
      idle_cycle();
      n++;
    end
    check("phase_reach", m_ph, p);
  endtask

  task automatic restart();
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic update_with(input logic j, input logic [PC_W-1:0] jd,
                             input logic c, input logic rt);
    run_to_phase(UPD_PHASE);
    cycle(1'b0, 1'b0, 1'b0, j, jd, c, rt);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; halt = 1'b0; jflag = 1'b0;
    jdest = '0; call = 1'b0; ret = 1'b0;
    m_mode = 0; m_ph = 0; m_pc = 0; m_err = 0;
    @(negedge clk);

    // Reset state
    cycle(1'b1, 1'b0, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    check("reset_pc", pc, 0);
    check("reset_running", running, 0);

    // Basic sequencing: pc 0 -> 1 -> 2
    cycle(1'b0, 1'b1, 1'b0, 1'b0, '0, 1'b0, 1'b0);
    repeat (11) idle_cycle();
    check("seq_pc", pc, 2);

    // Jump at update phase, ignored at phase 3
    update_with(1'b1, 12'h3A0, 1'b0, 1'b0);
    check("jump_dest", pc, 12'h3A0);
    run_to_phase(3);
    cycle(1'b0, 1'b0, 1'b0, 1'b1, 12'h123, 1'b1, 1'b1);
    check("jump_off_phase", pc, 12'h3A0);

    // Wrap from all-ones
    update_with(1'b1, 12'hFFF, 1'b0, 1'b0);
    update_with(1'b0, '0, 1'b0, 1'b0);
    check("pc_wrap", pc, 0);

    // Halt at phase 1: instruction completes, then frozen until rst
    run_to_phase(1);
    repeat (4) cycle(1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
    check("halt_pc", pc, 1);
    check("halt_running", running, 0);
    repeat (8) cycle(1'b0, 1'b1, 1'b0, 1'b1, 12'h055, 1'b0, 1'b0);
    check("halt_frozen", pc, 1);

    // Reset mid-instruction
    restart();
    repeat (7) idle_cycle();
    run_to_phase(3);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 12'h777, 1'b1, 1'b0);
    check("midrst_phase", phase, 0);
    check("midrst_pc", pc, 0);

`ifdef CALL_STACK_EN
    // Five nested calls on a depth-4 stack, then five returns
    restart();
    for (int i = 1; i <= 5; i++) update_with(1'b0, 12'(i * 12'h100), 1'b1, 1'b0);
    check("call5_pc", pc, 12'h500);
    check("call5_err", stk_err, 1);
    update_with(1'b0, '0, 1'b0, 1'b1);
    check("ret1", pc, 12'h301);
    update_with(1'b0, '0, 1'b0, 1'b1);
    check("ret2", pc, 12'h201);
    update_with(1'b0, '0, 1'b0, 1'b1);
    check("ret3", pc, 12'h101);
    update_with(1'b0, '0, 1'b0, 1'b1);
    check("ret4", pc, 12'h001);
    update_with(1'b0, '0, 1'b0, 1'b1);
    check("ret5_underflow", pc, 12'h002);
    // ret beats call: no push happens
    restart();
    update_with(1'b0, 12'h0AA, 1'b1, 1'b1);
    check("retcall_pc", pc, 1);
    update_with(1'b0, '0, 1'b0, 1'b1);
    check("retcall_nopush", pc, 2);
`endif

    // Randomized traffic against the model
    restart();
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 1) == 0),
            ($urandom_range(0, 15) == 0),
            ($urandom_range(0, 2) == 0),
            PC_W'($urandom_range(0, PC_MOD - 1)),
            ($urandom_range(0, 5) == 0),
            ($urandom_range(0, 5) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
PC_SEQUENCER -- requirements
Module: pc_sequencer

Interface
REQ-001 Parameter PC_W, default 12: program counter width in bits.
REQ-002 Parameter NPHASE, default 5: phases per instruction, legal range 2..8.
REQ-003 Parameter UPD_PHASE, default 2: phase index at which PC updates, legal range 0..NPHASE-1.
REQ-004 Parameter STACK_DEPTH, default 4: return-stack entries, legal range 1..16; used only with CALL_STACK_EN.
REQ-005 Port clk, input, 1: single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1: reset, synchronous, active-high.
REQ-007 Port run, input, 1: start request, sampled in IDLE.
REQ-008 Port halt, input, 1: stop request, level.
REQ-009 Port jflag, input, 1: take jump at the update phase.
REQ-010 Port jdest, input, PC_W: jump/call target.
REQ-011 Port call, input, 1: subroutine call at the update phase.
REQ-012 Port ret, input, 1: subroutine return at the update phase.
REQ-013 Port phase, output, 3: current phase index.
REQ-014 Port pc, output, PC_W: registered program counter.
REQ-015 Port pc_we, output, 1: high during the cycle in which pc is updated.
REQ-016 Port running, output, 1: high in RUN.
REQ-017 Port stk_err, output, 1: sticky stack overflow/underflow flag.

Function
REQ-018 FSM states: IDLE, RUN, HALT.
REQ-019 IDLE: phase=0 and pc held; if run=1, go to RUN next cycle with phase=0.
REQ-020 RUN: phase increments by 1 each cycle and wraps from NPHASE-1 to 0.
REQ-021 RUN: halt is acted on only when phase=NPHASE-1; then go to HALT with phase=0, and the current instruction completes.
REQ-022 HALT: phase=0, pc held, running=0, pc_we=0; HALT is left only via rst.
REQ-023 pc_we SHALL be 1 exactly in RUN cycles where phase=UPD_PHASE, combinationally from state and phase.
REQ-024 Update rule (edge ending the update cycle), priority ret > call > jflag > increment:
  - ret: pc = stack top.
  - call: pc = jdest.
  - jflag: pc = jdest.
  - otherwise: pc = pc+1, modulo 2^PC_W (all-ones wraps to 0).
REQ-025 jflag, jdest, call and ret are ignored outside the update cycle.

Reset
REQ-026 On rst=1 at a clock edge:
  - state=IDLE, phase=0, pc=0.
  - running=0, pc_we=0, stk_err=0.
  - stack emptied.
REQ-027 rst SHALL take priority over every other input in any state or phase, including mid-instruction.

Configuration
REQ-028 Macro CALL_STACK_EN: when defined, a STACK_DEPTH-entry LIFO return stack is compiled in.
REQ-029 With CALL_STACK_EN, call:
  - pushes pc+1 (wrapped) and sets pc=jdest.
  - when the stack is full, the push is dropped, the jump is still taken, and stk_err is set.
REQ-030 With CALL_STACK_EN, ret:
  - pops the top entry into pc.
  - when the stack is empty, sets pc=pc+1 and stk_err.
  - call and ret together: ret wins and no push occurs.
REQ-031 Without CALL_STACK_EN: no stack storage, call behaves as jflag, ret is ignored, and stk_err is tied 0.

Verification
REQ-032 Reset then run=1 (defaults) -> phase sequence 0,1,2,3,4,0...; pc_we at phase 2; pc 0->1->2 once per instruction.
REQ-033 jflag=1, jdest=0x3A0 during phase 2 -> pc=0x3A0 next cycle; jflag at phase 3 -> no effect.
REQ-034 pc=0xFFF, no jump -> pc=0x000 after the update.
REQ-035 halt=1 asserted at phase 1 -> instruction completes, HALT entered after phase 4, pc frozen, run ignored until rst.
REQ-036 CALL_STACK_EN, depth 4:
  - 5 nested calls -> fifth call jumps, stk_err=1.
  - 4 rets -> return addresses in reverse order.
  - fifth ret -> pc+1.
REQ-037 rst asserted at phase 3 mid-instruction -> next cycle IDLE, phase=0, pc=0, stk_err=0.
